conv_window_gen: RTL



---
 rtl/conv_window_gen.sv | 125 ++++++++++++
 1 files changed

// File: rtl/conv_window_gen.sv
// Turns a raster pixel stream into 3x3 windows for the convolution stage.
// Two line buffers hold the previous rows. One start/done handshake is made per window.
module conv_window_gen #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  pix_in,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic [71:0] data_out,
    output logic        start,
    input  logic        done,
    output logic        frame_done
);
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    typedef enum logic [1:0] {FILL, ISSUE, GAP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [71:0]   data_q, data_d;
    logic          last_q, last_d;
    logic [7:0]    win_q [3][3];
    logic [7:0]    win_d [3][3];
    logic [7:0]    lb0_q [IMG_W];
    logic [7:0]    lb1_q [IMG_W];
    logic [7:0]    lb0_rd, lb1_rd;
    logic          accept, complete;

    assign accept   = pix_valid & pix_ready;
    assign complete = (row_q >= RW'(2)) && (col_q >= CW'(2));
    assign lb0_rd   = lb0_q[col_q];
    assign lb1_rd   = lb1_q[col_q];

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= FILL;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL:    if (accept && complete) state_d = ISSUE;
            ISSUE:   if (done) state_d = GAP;
            GAP:     state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    // Outputs; start drops as soon as reset asserts because the state is cleared asynchronously
    always_comb begin
        pix_ready  = (state_q == FILL) && !reset;
        start      = (state_q == ISSUE);
        frame_done = (state_q == GAP) && last_q;
    end

    assign data_out = data_q;

    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        data_d = data_q;
        last_d = last_q;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                win_d[r][c] = win_q[r][c];
        if (accept) begin
            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = win_q[r][2];
            end
            win_d[0][2] = lb0_rd;
            win_d[1][2] = lb1_rd;
            win_d[2][2] = pix_in;
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
            if (complete) begin
                for (int r = 0; r < 3; r++)
                    for (int c = 0; c < 3; c++)
                        data_d[(r*3+c)*8 +: 8] = win_d[r][c];
                last_d = (row_q == ROW_LAST) && (col_q == COL_LAST);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_q  <= '0;
            row_q  <= '0;
            data_q <= '0;
            last_q <= 1'b0;
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    win_q[r][c] <= '0;
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            data_q <= data_d;
            last_q <= last_d;
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    win_q[r][c] <= win_d[r][c];
        end
    end

    // Line buffers are never reset; row/col gating keeps stale entries out of windows
    always_ff @(posedge clk) begin
        if (accept) begin
            lb0_q[col_q] <= lb1_rd;
            lb1_q[col_q] <= pix_in;
        end
    end
endmodule
